frame_mem_unit: RTL and testbench

Sample-memory execution stage downstream of the instruction decoder. It accepts one decoded memory/frame operation at a time (opcode, address, block pointer, data, frame size, direction) and executes it against an internal synchronous sample RAM. Single-word loads and stores are supported, as are multi-word frame transfers over valid/ready streams. It pulses `instrComplete` when the operation retires so the decoder can advance its PC.

---
 rtl/frame_mem_unit.sv | 193 +++++++++++++++++++
 tb/tb_frame_mem_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_mem_unit.sv
// frame_mem_unit: executes decoded LOAD/STORE/FRAME ops against an internal synchronous sample RAM.
// Define FRAME_IN_EN to enable input-stream frames (outputFrame=0); otherwise they retire as illegal.
module frame_mem_unit #(
  parameter int AW = 10
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        opValid,
  output logic        opReady,
  input  logic [2:0]  opcode,
  input  logic [15:0] address,
  input  logic [7:0]  blkPtr,
  input  logic [15:0] data,
  input  logic [3:0]  frameSize,
  input  logic        outputFrame,
  output logic        instrComplete,
  output logic        opErr,
  output logic [15:0] rdData,
  output logic [15:0] frameData,
  output logic        frameValid,
  input  logic        frameReady,
  input  logic [15:0] inData,
  input  logic        inValid,
  output logic        inReady
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_FRAME = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_OUT_RD   = 3'd2,
    S_OUT_SEND = 3'd3,
    S_IN_RECV  = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    size_q, size_d;
  logic [3:0]    idx_q, idx_d;
  logic          err_q, err_d;
  logic [15:0]   frame_base_s;
  logic [AW-1:0] word_addr_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic [15:0]   wr_data_s;
  logic          opReady_q, instrComplete_q, opErr_q, frameValid_q;
  logic [15:0]   rdData_q, frameData_q;
  logic [15:0]   mem_q [2**AW];
  logic          unused_s;

  // Frame base wraps mod 2^16; only the low AW bits ever address the RAM.
  assign frame_base_s = address + {4'h0, blkPtr, 4'h0};
  assign word_addr_s  = addr_q + AW'(idx_q);

  // Next-state, op capture and RAM write-port selection
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    idx_d     = idx_q;
    err_d     = err_q;
    wr_en_s   = 1'b0;
    wr_addr_s = {AW{1'b0}};
    wr_data_s = 16'h0000;
    case (state_q)
      S_IDLE: begin
        if (opValid) begin
          addr_d = address[AW-1:0];
          size_d = frameSize;
          idx_d  = 4'h0;
          err_d  = 1'b0;
          case (opcode)
            OP_NOP:   state_d = S_DONE;
            OP_LOAD:  state_d = S_RD_WAIT;
            OP_STORE: begin
              state_d   = S_DONE;
              wr_en_s   = 1'b1;
              wr_addr_s = address[AW-1:0];
              wr_data_s = data;
            end
            OP_FRAME: begin
              addr_d = frame_base_s[AW-1:0];
              if (outputFrame) begin
                state_d = S_OUT_RD;
              end else begin
`ifdef FRAME_IN_EN
                state_d = S_IN_RECV;
`else
                state_d = S_DONE;
                err_d   = 1'b1;
`endif
              end
            end
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: state_d = S_DONE;
      S_OUT_RD:  state_d = S_OUT_SEND;
      S_OUT_SEND: begin
        if (frameReady) begin
          idx_d   = idx_q + 4'h1;
          state_d = (idx_q == size_q) ? S_DONE : S_OUT_RD;
        end else begin
          state_d = S_OUT_SEND;
        end
      end
`ifdef FRAME_IN_EN
      S_IN_RECV: begin
        if (inValid) begin
          wr_en_s   = 1'b1;
          wr_addr_s = word_addr_s;
          wr_data_s = inData;
          idx_d     = idx_q + 4'h1;
          state_d   = (idx_q == size_q) ? S_DONE : S_IN_RECV;
        end else begin
          state_d = S_IN_RECV;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and registered outputs, decoded from the next state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q         <= S_IDLE;
      addr_q          <= {AW{1'b0}};
      size_q          <= 4'h0;
      idx_q           <= 4'h0;
      err_q           <= 1'b0;
      opReady_q       <= 1'b1;
      instrComplete_q <= 1'b0;
      opErr_q         <= 1'b0;
      frameValid_q    <= 1'b0;
      rdData_q        <= 16'h0000;
      frameData_q     <= 16'h0000;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      size_q          <= size_d;
      idx_q           <= idx_d;
      err_q           <= err_d;
      opReady_q       <= (state_d == S_IDLE);
      instrComplete_q <= (state_d == S_DONE);
      opErr_q         <= (state_d == S_DONE) && err_d;
      frameValid_q    <= (state_d == S_OUT_SEND);
      if (state_q == S_RD_WAIT) rdData_q <= mem_q[addr_q];
      if (state_q == S_OUT_RD) frameData_q <= mem_q[word_addr_s];
    end
  end

  // Sample RAM write port; contents deliberately survive reset
  always_ff @(posedge CLK) begin
    if (wr_en_s) mem_q[wr_addr_s] <= wr_data_s;
  end

`ifdef FRAME_IN_EN
  logic inReady_q;

  // Input-stream ready, high exactly while receiving
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) inReady_q <= 1'b0;
    else        inReady_q <= (state_d == S_IN_RECV);
  end

  assign inReady  = inReady_q;
  assign unused_s = ^{frame_base_s[15:AW], address[15:AW]};
`else
  assign inReady  = 1'b0;
  assign unused_s = ^{frame_base_s[15:AW], address[15:AW], inData, inValid};
`endif

  assign opReady       = opReady_q;
  assign instrComplete = instrComplete_q;
  assign opErr         = opErr_q;
  assign rdData        = rdData_q;
  assign frameData     = frameData_q;
  assign frameValid    = frameValid_q;

endmodule

// File: tb/tb_frame_mem_unit.sv
// Directed + randomized bench for frame_mem_unit against a word-array reference model.
module tb_frame_mem_unit;
  localparam int AW = 10;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        opValid, opReady;
  logic [2:0]  opcode;
  logic [15:0] address;
  logic [7:0]  blkPtr;
  logic [15:0] data;
  logic [3:0]  frameSize;
  logic        outputFrame;
  logic        instrComplete, opErr;
  logic [15:0] rdData, frameData;
  logic        frameValid, frameReady;
  logic [15:0] inData;
  logic        inValid, inReady;

  frame_mem_unit #(.AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .opValid(opValid), .opReady(opReady),
    .opcode(opcode), .address(address), .blkPtr(blkPtr), .data(data),
    .frameSize(frameSize), .outputFrame(outputFrame),
    .instrComplete(instrComplete), .opErr(opErr), .rdData(rdData),
    .frameData(frameData), .frameValid(frameValid), .frameReady(frameReady),
    .inData(inData), .inValid(inValid), .inReady(inReady)
  );

  always #5 CLK = ~CLK;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] model [1024];
  logic [15:0] last_rd = 16'h0000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op, returning at the negedge of the cycle after the accept edge.
  task automatic start_op(input logic [2:0] opc, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] d, input logic [3:0] fs, input logic dir);
    @(negedge CLK);
    chk("op_ready_idle", {15'd0, opReady}, 16'd1);
    opValid = 1'b1; opcode = opc; address = a; blkPtr = b; data = d;
    frameSize = fs; outputFrame = dir;
    @(negedge CLK);
    opValid = 1'b0;
    opcode = 3'($urandom); address = 16'($urandom); blkPtr = 8'($urandom);
    data = 16'($urandom); frameSize = 4'($urandom); outputFrame = 1'($urandom);
  endtask

  task automatic expect_done(input logic err);
    chk("done_ic", {15'd0, instrComplete}, 16'd1);
    chk("done_err", {15'd0, opErr}, {15'd0, err});
    chk("done_busy", {15'd0, opReady}, 16'd0);
    @(negedge CLK);
    chk("after_ic", {15'd0, instrComplete}, 16'd0);
    chk("after_err", {15'd0, opErr}, 16'd0);
    chk("after_ready", {15'd0, opReady}, 16'd1);
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] d);
    start_op(3'b010, a, 8'($urandom), d, 4'($urandom), 1'($urandom));
    model[a[9:0]] = d;
    expect_done(1'b0);
  endtask

  task automatic do_load(input logic [15:0] a);
    start_op(3'b001, a, 8'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
    chk("ld_early_ic", {15'd0, instrComplete}, 16'd0);
    chk("ld_busy", {15'd0, opReady}, 16'd0);
    @(negedge CLK);
    expect_done(1'b0);
    last_rd = model[a[9:0]];
    chk("ld_data", rdData, last_rd);
  endtask

  task automatic do_simple(input logic [2:0] opc, input logic err);
    start_op(opc, 16'($urandom), 8'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
    expect_done(err);
    chk("simple_rd_held", rdData, last_rd);
  endtask

  task automatic frame_out(input logic [15:0] a, input logic [7:0] b, input logic [3:0] fs,
                           input int stall_i, input int stall_n);
    logic [15:0] base;
    logic [9:0]  idx;
    logic [15:0] exp;
    base = a + {4'h0, b, 4'h0};
    frameReady = 1'b0;
    start_op(3'b011, a, b, 16'($urandom), fs, 1'b1);
    chk("fo_rd_valid", {15'd0, frameValid}, 16'd0);
    for (int i = 0; i <= int'(fs); i++) begin
      idx = base[9:0] + 10'(i);
      exp = model[idx];
      @(negedge CLK);
      chk("fo_valid", {15'd0, frameValid}, 16'd1);
      chk("fo_data", frameData, exp);
      if (i == stall_i) begin
        for (int s = 0; s < stall_n; s++) begin
          @(negedge CLK);
          chk("fo_stall_valid", {15'd0, frameValid}, 16'd1);
          chk("fo_stall_data", frameData, exp);
        end
      end
      frameReady = 1'b1;
      @(negedge CLK);
      frameReady = 1'b0;
      if (i < int'(fs)) begin
        chk("fo_gap_valid", {15'd0, frameValid}, 16'd0);
        chk("fo_no_ic", {15'd0, instrComplete}, 16'd0);
      end
    end
    chk("fo_end_valid", {15'd0, frameValid}, 16'd0);
    expect_done(1'b0);
  endtask

`ifdef FRAME_IN_EN
  task automatic frame_in(input logic [15:0] a, input logic [7:0] b, input logic [3:0] fs,
                          input logic [15:0] w0, input logic [15:0] w1, input logic directed);
    logic [15:0] base;
    logic [9:0]  idx;
    int          n = 0;
    int          budget = 0;
    base = a + {4'h0, b, 4'h0};
    inValid = 1'b0;
    start_op(3'b011, a, b, 16'($urandom), fs, 1'b0);
    chk("fi_ready", {15'd0, inReady}, 16'd1);
    chk("fi_no_ic", {15'd0, instrComplete}, 16'd0);
    while (n <= int'(fs) && budget < 200) begin
      inValid = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
      inData  = directed ? ((n == 0) ? w0 : w1) : 16'($urandom);
      @(negedge CLK);
      if (inValid) begin
        idx = base[9:0] + 10'(n);
        model[idx] = inData;
        n++;
      end
      budget++;
      if (n <= int'(fs)) chk("fi_ready_hold", {15'd0, inReady}, 16'd1);
    end
    inValid = 1'b0;
    chk("fi_count", 16'(n), 16'(fs) + 16'd1);
    chk("fi_end_ready", {15'd0, inReady}, 16'd0);
    expect_done(1'b0);
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    RST_N = 1'b0; opValid = 1'b0; opcode = 3'd0; address = 16'h0; blkPtr = 8'h0;
    data = 16'h0; frameSize = 4'h0; outputFrame = 1'b0; frameReady = 1'b0;
    inData = 16'h0; inValid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_opReady", {15'd0, opReady}, 16'd1);
    chk("rst_ic", {15'd0, instrComplete}, 16'd0);
    chk("rst_err", {15'd0, opErr}, 16'd0);
    chk("rst_rdData", rdData, 16'h0000);
    chk("rst_frameData", frameData, 16'h0000);
    chk("rst_frameValid", {15'd0, frameValid}, 16'd0);
    chk("rst_inReady", {15'd0, inReady}, 16'd0);
    RST_N = 1'b1;

    // Fill every word, with random upper address bits that must be ignored.
    for (int k = 0; k < 1024; k++)
      do_store(16'(k) | (16'($urandom_range(0, 63)) << 10), 16'($urandom));

    do_store(16'h0005, 16'hBEEF);
    do_load(16'h0005);
    chk("tp_beef", rdData, 16'hBEEF);

    for (int k = 0; k < 4; k++) do_store(16'h0100 + 16'(k), 16'(k + 1));
    frame_out(16'h0100, 8'h00, 4'd3, 2, 3);

    do_simple(3'b101, 1'b1);
    do_simple(3'b000, 1'b0);
    frame_out(16'h03FF, 8'h00, 4'd1, -1, 0);
    frame_out(16'hFFF8, 8'h01, 4'd15, 7, 1);

`ifdef FRAME_IN_EN
    frame_in(16'h0000, 8'h02, 4'd1, 16'hAAAA, 16'h5555, 1'b1);
    do_load(16'h0020);
    chk("tp_in0", rdData, 16'hAAAA);
    do_load(16'h0021);
    chk("tp_in1", rdData, 16'h5555);
`else
    start_op(3'b011, 16'h0000, 8'h02, 16'h0000, 4'd1, 1'b0);
    chk("noin_ready", {15'd0, inReady}, 16'd0);
    expect_done(1'b1);
    do_load(16'h0020);
    do_load(16'h0021);
`endif

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 5))
        0: do_store(16'($urandom), 16'($urandom));
        1: do_load(16'($urandom));
        2: begin
          logic [3:0] fs;
          fs = 4'($urandom);
          frame_out(16'($urandom), 8'($urandom), fs, $urandom_range(0, int'(fs)), $urandom_range(0, 3));
        end
        3: do_simple(3'($urandom_range(4, 7)), 1'b1);
`ifdef FRAME_IN_EN
        4: frame_in(16'($urandom), 8'($urandom), 4'($urandom), 16'h0, 16'h0, 1'b0);
`else
        4: do_simple(3'b000, 1'b0);
`endif
        default: do_load(16'($urandom));
      endcase
    end

    // Asynchronous reset while word 1 of 4 is on the output stream.
    frameReady = 1'b0;
    start_op(3'b011, 16'h0200, 8'h00, 16'h0000, 4'd3, 1'b1);
    @(negedge CLK);
    chk("rs_w0_valid", {15'd0, frameValid}, 16'd1);
    frameReady = 1'b1;
    @(negedge CLK);
    frameReady = 1'b0;
    @(negedge CLK);
    chk("rs_w1_valid", {15'd0, frameValid}, 16'd1);
    chk("rs_w1_data", frameData, model[10'h201]);
    #2 RST_N = 1'b0;
    #1;
    chk("rs_async_valid", {15'd0, frameValid}, 16'd0);
    chk("rs_async_ready", {15'd0, opReady}, 16'd1);
    chk("rs_async_ic", {15'd0, instrComplete}, 16'd0);
    @(negedge CLK);
    chk("rs_hold_ic", {15'd0, instrComplete}, 16'd0);
    RST_N = 1'b1;
    last_rd = 16'h0000;
    @(negedge CLK);
    chk("rs_after_ic", {15'd0, instrComplete}, 16'd0);
    chk("rs_after_ready", {15'd0, opReady}, 16'd1);
    do_load(16'h0201);
    do_load(16'h0005);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
